imem_fetch_ctrl: RTL and testbench
==================================

// Module: imem_fetch_ctrl
// PURPOSE
//  Fetch sequencer in front of the 64K x 16 instruction memory. Owns the PC and drives
//  imem addr/rd_en. Captures each returned word into an IF/ID register with a valid flag.
//  Honours decode stall, branch/jump redirect (flush) and the HLT opcode.
//  Sits between Instruction_Memory and the decode stage.
// PARAMETERS
//  ADDR_W      16       PC / imem address width
//  DATA_W      16       instruction width
//  RESET_PC    16'h0000 PC loaded on reset
//  NOP_INSTR   16'h0000 word driven on instr_out while instr_vld=0
//  HLT_OPCODE  4'hF     instr[15:12] value that halts fetch
// PORTS
//  clk         in   1       system clock; all state changes on posedge
//  rst_n       in   1       asynchronous active-low reset
//  imem_addr   out  ADDR_W  address to imem (= pc, combinational from pc reg)
//  imem_rd_en  out  1       imem read enable (combinational, see BEHAVIOUR)
//  imem_instr  in   DATA_W  imem read data; valid before the posedge of the issuing cycle
//  stall       in   1       decode cannot accept; hold IF/ID and PC
//  flush       in   1       redirect fetch (taken branch/jump/resume)
//  flush_addr  in   ADDR_W  redirect target, sampled when flush=1
//  instr_out   out  DATA_W  IF/ID instruction
//  pc_out      out  ADDR_W  address of instr_out
//  instr_vld   out  1       instr_out holds a real fetched instruction
//  halted      out  1       fetch stopped on HLT
// BEHAVIOUR
//  Reset (async assert): pc=RESET_PC, state=FETCH, instr_out=NOP_INSTR, pc_out=RESET_PC.
//   Also instr_vld=0, halted=0. First fetch is issued in the first cycle after deassert.
//  States: FETCH, HALT (2-state FSM, state reg only).
//  imem_rd_en = (state==FETCH) & ~stall & ~flush. imem_addr = pc in all cycles.
//  Priority per posedge: flush > stall > normal.
//  flush=1 (any state, regardless of stall):
//   - pc<=flush_addr; instr_out<=NOP_INSTR; instr_vld<=0.
//   - state<=FETCH; halted<=0.
//   - Redirect penalty: exactly 1 bubble cycle.
//  stall=1, flush=0: pc, instr_out, pc_out, instr_vld, state, halted all hold.
//   rd_en=0 so the imem output latch also holds.
//  FETCH, no stall/flush: instr_out<=imem_instr; pc_out<=pc; instr_vld<=1; pc<=pc+1.
//   - pc+1 is modulo 2^ADDR_W: 16'hFFFF -> 16'h0000, no flag.
//   - If imem_instr[15:12]==HLT_OPCODE: HLT is delivered with instr_vld=1, and
//     state<=HALT, halted<=1; pc still advances to HLT addr+1.
//  HALT, no stall/flush: instr_out<=NOP_INSTR; instr_vld<=0; pc holds; halted stays 1.
//   Leaves HALT only via flush or reset.
//  Throughput: 1 instr/cycle when unstalled; latency imem addr -> instr_out = 1 posedge.
//  Reset mid-operation: all regs return to reset values immediately (async); no partial state.
//  flush and HLT fetched in the same cycle: flush wins, HLT is discarded, halted stays 0.
// STRUCTURE
//  Shared package wisc_pkg: opcode constants (HLT_OPCODE et al.), NOP encoding,
//   fetch_state_t enum {FETCH, HALT}.
//  Flat module. Next-PC mux (flush_addr / pc+1 / pc) is a natural sub-module:
//   pc_next_sel. Optional; only if the decode redirect path reuses it.
// TESTING
//  1 Reset release, no stall, imem holds 0x1000..0x1003 at 0..3:
//    instr_out = 0x1000,0x1001,0x1002 on posedges 1..3; pc_out = 0,1,2; instr_vld=1.
//  2 stall=1 for 3 cycles after word 0x1001:
//    instr_out/pc_out frozen at 0x1001/1; imem_rd_en=0; next word after release = 0x1002.
//  3 flush with flush_addr=0x0040 while stall=1:
//    next cycle instr_vld=0, instr_out=NOP; following cycle pc_out=0x0040.
//  4 HLT (0xF000) at addr 5:
//    instr_out=0xF000 vld=1, then halted=1, vld=0, rd_en=0 indefinitely;
//    flush to 0x0010 clears halted and resumes at 0x0010.
//  5 Wrap: flush_addr=0xFFFF, then free-run:
//    pc_out sequence 0xFFFF, 0x0000, 0x0001.
//  6 rst_n asserted mid-stream, between clock edges:
//    outputs reach reset values without a clock; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/imem_fetch_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl_pkg
//   Shared definitions for the instruction fetch front end: default widths,
//   the NOP encoding, opcode constants and the fetch FSM state type.
// -----------------------------------------------------------------------------
package imem_fetch_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;

    // Encodings
    localparam logic [15:0] NOP_ENC = 16'h0000;
    localparam logic [3:0]  OP_HLT  = 4'hF;

    typedef enum logic {
        FETCH = 1'b0,
        HALT  = 1'b1
    } fetch_state_t;

endpackage : imem_fetch_ctrl_pkg

// File: rtl/imem_fetch_ctrl_pc_next_sel.sv
// -----------------------------------------------------------------------------
// pc_next_sel
//   Next-PC selector for the fetch sequencer. Priority: redirect target,
//   then sequential increment (modulo 2^ADDR_W), otherwise hold.
// Ports:
//   pc         in   ADDR_W  current program counter
//   flush      in   1       redirect request
//   flush_addr in   ADDR_W  redirect target
//   advance    in   1       a fetch is being accepted this cycle
//   pc_next    out  ADDR_W  value the PC register loads at the next posedge
// -----------------------------------------------------------------------------
module pc_next_sel #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_addr,
    input  logic              advance,
    output logic [ADDR_W-1:0] pc_next
);

    always_comb begin
        pc_next = pc;
        if (flush) begin
            pc_next = flush_addr;
        end else if (advance) begin
            pc_next = pc + ADDR_W'(1);
        end
    end

endmodule : pc_next_sel

// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
//   Fetch sequencer in front of the instruction memory. Owns the PC, issues
//   imem reads and captures each returned word into the IF/ID register.
//   Honours decode stall, redirect (flush) and the HLT opcode.
// Ports:
//   clk         in   1       system clock, posedge active
//   rst_n       in   1       asynchronous active-low reset
//   imem_addr   out  ADDR_W  imem address (= pc)
//   imem_rd_en  out  1       imem read enable
//   imem_instr  in   DATA_W  imem read data for the current address
//   stall       in   1       decode cannot accept; hold IF/ID and PC
//   flush       in   1       redirect fetch to flush_addr
//   flush_addr  in   ADDR_W  redirect target
//   instr_out   out  DATA_W  IF/ID instruction
//   pc_out      out  ADDR_W  address of instr_out
//   instr_vld   out  1       instr_out holds a real fetched instruction
//   halted      out  1       fetch stopped on HLT
// -----------------------------------------------------------------------------
module imem_fetch_ctrl
    import imem_fetch_ctrl_pkg::*;
#(
    parameter int unsigned        ADDR_W     = ADDR_W_DEF,
    parameter int unsigned        DATA_W     = DATA_W_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
    parameter logic [DATA_W-1:0]  NOP_INSTR  = NOP_ENC,
    parameter logic [3:0]         HLT_OPCODE = OP_HLT
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_rd_en,
    input  logic [DATA_W-1:0] imem_instr,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_addr,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_vld,
    output logic              halted
);

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] pc, pc_next;
    logic [DATA_W-1:0] instr_next;
    logic [ADDR_W-1:0] pc_out_next;
    logic              vld_next;
    logic              is_hlt;

    assign imem_addr  = pc;
    assign imem_rd_en = (state == FETCH) && !stall && !flush;
    assign is_hlt     = (imem_instr[DATA_W-1 -: 4] == HLT_OPCODE);

    // halted is exactly "FSM sits in HALT": both set on HLT capture and both
    // cleared only by flush or reset, so no separate flag register is kept.
    assign halted = (state == HALT);

    pc_next_sel #(
        .ADDR_W (ADDR_W)
    ) u_pc_next_sel (
        .pc         (pc),
        .flush      (flush),
        .flush_addr (flush_addr),
        .advance    (imem_rd_en),
        .pc_next    (pc_next)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and IF/ID next values; priority flush > stall > normal
    always_comb begin
        state_next  = state;
        instr_next  = instr_out;
        pc_out_next = pc_out;
        vld_next    = instr_vld;
        if (flush) begin
            state_next = FETCH;
            instr_next = NOP_INSTR;
            vld_next   = 1'b0;
        end else if (!stall) begin
            case (state)
                FETCH: begin
                    instr_next  = imem_instr;
                    pc_out_next = pc;
                    vld_next    = 1'b1;
                    if (is_hlt) begin
                        state_next = HALT;
                    end
                end
                HALT: begin
                    instr_next = NOP_INSTR;
                    vld_next   = 1'b0;
                end
                default: state_next = FETCH;
            endcase
        end
    end

    // PC and IF/ID registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            instr_out <= NOP_INSTR;
            pc_out    <= RESET_PC;
            instr_vld <= 1'b0;
        end else begin
            pc        <= pc_next;
            instr_out <= instr_next;
            pc_out    <= pc_out_next;
            instr_vld <= vld_next;
        end
    end

endmodule : imem_fetch_ctrl

// File: tb/tb_imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//   Directed bench for imem_fetch_ctrl with a behavioural 64K x 16 memory.
// -----------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] imem_addr;
    logic        imem_rd_en;
    logic [15:0] imem_instr;
    logic        stall;
    logic        flush;
    logic [15:0] flush_addr;
    logic [15:0] instr_out;
    logic [15:0] pc_out;
    logic        instr_vld;
    logic        halted;

    logic [15:0] mem [0:65535];

    int vectors;
    int miscompares;

    imem_fetch_ctrl #(
        .ADDR_W     (16),
        .DATA_W     (16),
        .RESET_PC   (16'h0000),
        .NOP_INSTR  (16'h0000),
        .HLT_OPCODE (4'hF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_rd_en (imem_rd_en),
        .imem_instr (imem_instr),
        .stall      (stall),
        .flush      (flush),
        .flush_addr (flush_addr),
        .instr_out  (instr_out),
        .pc_out     (pc_out),
        .instr_vld  (instr_vld),
        .halted     (halted)
    );

    assign imem_instr = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one posedge, then sample on the following negedge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_ifid(input string tag, input logic [15:0] ins,
                              input logic [15:0] pco, input logic vld);
        check({tag, ".instr"}, 32'(instr_out), 32'(ins));
        check({tag, ".pc_out"}, 32'(pc_out), 32'(pco));
        check({tag, ".vld"}, 32'(instr_vld), 32'(vld));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        for (int unsigned i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0000] = 16'h1000;
        mem[16'h0001] = 16'h1001;
        mem[16'h0002] = 16'h1002;
        mem[16'h0003] = 16'h1003;
        mem[16'h0004] = 16'h1004;
        mem[16'h0005] = 16'hF000;
        mem[16'h0010] = 16'h2010;
        mem[16'h0011] = 16'hF111;
        mem[16'h0040] = 16'h4040;
        mem[16'hFFFF] = 16'h3FFF;

        rst_n      = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        flush_addr = 16'h0000;

        // Reset state
        #12;
        check_ifid("rst", 16'h0000, 16'h0000, 1'b0);
        check("rst.halted", 32'(halted), 32'h0);
        check("rst.addr", 32'(imem_addr), 32'h0);
        check("rst.rd_en", 32'(imem_rd_en), 32'h1);

        // Test 1: free-run from reset
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_ifid("t1.e1", 16'h1000, 16'h0000, 1'b1);
        step();
        check_ifid("t1.e2", 16'h1001, 16'h0001, 1'b1);

        // Test 2: stall 3 cycles after 0x1001
        stall = 1'b1;
        #1;
        check("t2.rd_en", 32'(imem_rd_en), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_ifid("t2.hold", 16'h1001, 16'h0001, 1'b1);
            check("t2.addr", 32'(imem_addr), 32'h2);
            check("t2.rd_en_h", 32'(imem_rd_en), 32'h0);
        end
        stall = 1'b0;
        step();
        check_ifid("t2.rel", 16'h1002, 16'h0002, 1'b1);

        // Test 3: flush while stalled
        stall      = 1'b1;
        flush      = 1'b1;
        flush_addr = 16'h0040;
        #1;
        check("t3.rd_en", 32'(imem_rd_en), 32'h0);
        step();
        check("t3.bub.instr", 32'(instr_out), 32'h0);
        check("t3.bub.vld", 32'(instr_vld), 32'h0);
        check("t3.addr", 32'(imem_addr), 32'h40);
        stall = 1'b0;
        flush = 1'b0;
        step();
        check_ifid("t3.tgt", 16'h4040, 16'h0040, 1'b1);

        // Test 4: HLT at address 5
        flush      = 1'b1;
        flush_addr = 16'h0003;
        step();
        check("t4.bub.vld", 32'(instr_vld), 32'h0);
        flush = 1'b0;
        step();
        check_ifid("t4.a3", 16'h1003, 16'h0003, 1'b1);
        step();
        check_ifid("t4.a4", 16'h1004, 16'h0004, 1'b1);
        step();
        check_ifid("t4.hlt", 16'hF000, 16'h0005, 1'b1);
        check("t4.halted", 32'(halted), 32'h1);
        check("t4.rd_en", 32'(imem_rd_en), 32'h0);
        check("t4.addr", 32'(imem_addr), 32'h6);
        for (int i = 0; i < 3; i++) begin
            step();
            check_ifid("t4.idle", 16'h0000, 16'h0005, 1'b0);
            check("t4.idle.halted", 32'(halted), 32'h1);
            check("t4.idle.rd_en", 32'(imem_rd_en), 32'h0);
            check("t4.idle.addr", 32'(imem_addr), 32'h6);
        end
        flush      = 1'b1;
        flush_addr = 16'h0010;
        step();
        check("t4.res.halted", 32'(halted), 32'h0);
        check("t4.res.vld", 32'(instr_vld), 32'h0);
        flush = 1'b0;
        #1;
        check("t4.res.rd_en", 32'(imem_rd_en), 32'h1);
        step();
        check_ifid("t4.resume", 16'h2010, 16'h0010, 1'b1);

        // flush coincides with HLT fetch at 0x11: HLT discarded
        check("t4.addr11", 32'(imem_addr), 32'h11);
        flush      = 1'b1;
        flush_addr = 16'hFFFF;
        step();
        check("t4.fh.halted", 32'(halted), 32'h0);
        check("t4.fh.vld", 32'(instr_vld), 32'h0);
        check("t4.fh.instr", 32'(instr_out), 32'h0);

        // Test 5: wrap
        flush = 1'b0;
        step();
        check_ifid("t5.ffff", 16'h3FFF, 16'hFFFF, 1'b1);
        step();
        check_ifid("t5.0000", 16'h1000, 16'h0000, 1'b1);
        step();
        check_ifid("t5.0001", 16'h1001, 16'h0001, 1'b1);

        // Test 6: async reset mid-cycle
        #2;
        rst_n = 1'b0;
        #1;
        check_ifid("t6.rst", 16'h0000, 16'h0000, 1'b0);
        check("t6.addr", 32'(imem_addr), 32'h0);
        check("t6.halted", 32'(halted), 32'h0);
        step();
        check_ifid("t6.held", 16'h0000, 16'h0000, 1'b0);
        rst_n = 1'b1;
        step();
        check_ifid("t6.restart", 16'h1000, 16'h0000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_imem_fetch_ctrl
